// File: rtl/step_pkg.sv
// Shared types and constants for the step motor sequencer.
// Phase table, FSM states, reset index and display digit limit.
package step_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam logic [3:0] PHASE_TBL [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  localparam logic [2:0] IDX_RST = 3'd1;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/sense_counter.sv
// Slot sensor path: 2-FF synchronizer, rising-edge detect,
// and a 0..9 wrapping counter with enable and clear.
module sense_counter
  import step_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sense,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] cnt
);

  logic s1, s2, s3;
  logic rise;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sense;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // clear outranks a coincident edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (en && rise) begin
      cnt <= (cnt == BCD_MAX) ? 4'd0 : cnt + 4'd1;
    end
  end

endmodule

// File: rtl/step_motor_ctrl.sv
// Command-driven 4-phase step motor sequencer with
// sensor pulse counting and move completion report.
module step_motor_ctrl
  import step_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic             cmd_half,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic             motor_sense,
  output logic [3:0]       step_motor,
  output logic             busy,
  output logic             done,
  output logic [3:0]       sense_cnt,
  output logic [CNT_W-1:0] steps_left
);

  state_t           state;
  logic [2:0]       idx;
  logic             dir;
  logic             half;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] div_cnt;

  logic             tick;
  logic             start;
  logic             last;
  logic [2:0]       stride;
  logic [2:0]       idx_step;
  logic [2:0]       idx_go;
  logic [DIV_W-1:0] div_ld;

  assign cmd_ready = (state == S_IDLE);
  assign start     = cmd_valid && cmd_ready
                   && (cmd_steps != '0);
  assign tick      = (div_cnt == div_m1);
  assign last      = (steps_left == CNT_W'(1));
  assign stride    = half ? 3'd1 : 3'd2;
  assign idx_step  = dir ? idx + stride
                         : idx - stride;
  // full-step runs on odd (two-coil) phases
  assign idx_go    = (!cmd_half && !idx[0])
                   ? idx + 3'd1 : idx;
  assign div_ld    = (cmd_div == '0)
                   ? '0 : cmd_div - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= IDX_RST;
      dir        <= 1'b0;
      half       <= 1'b0;
      div_m1     <= '0;
      div_cnt    <= '0;
      step_motor <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            idx        <= idx_go;
            step_motor <= PHASE_TBL[idx_go];
            steps_left <= cmd_steps;
            div_cnt    <= '0;
            dir        <= cmd_dir;
            half       <= cmd_half;
            div_m1     <= div_ld;
          end else if (cmd_valid) begin
            done <= 1'b1;
          end
        end
        S_RUN: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            idx        <= idx_step;
            step_motor <= PHASE_TBL[idx_step];
            steps_left <= steps_left - 1'b1;
          end
          if (abort || (tick && last)) begin
            state   <= S_STOP;
            div_cnt <= '0;
          end
        end
        S_STOP: begin
          if (tick) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            step_motor <= 4'b0000;
            div_cnt    <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          step_motor <= 4'b0000;
        end
      endcase
    end
  end

  sense_counter u_sense (
    .clk   (clk),
    .rst   (rst),
    .sense (motor_sense),
    .en    (busy),
    .clr   (start),
    .cnt   (sense_cnt)
  );

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Scoreboard bench for step_motor_ctrl: per-cycle expected
// coil/done/busy entries queued per command and popped each clock.
module tb_step_motor_ctrl;

  localparam int CNT_W = 12;
  localparam int DIV_W = 16;

  typedef struct {
    logic [3:0] coil;
    logic       done;
    logic       busy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic             cmd_half = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [DIV_W-1:0] cmd_div = '0;
  logic             abort = 1'b0;
  logic             motor_sense = 1'b0;
  logic [3:0]       step_motor;
  logic             busy;
  logic             done;
  logic [3:0]       sense_cnt;
  logic [CNT_W-1:0] steps_left;

  int total = 0;
  int bad = 0;

  exp_t       exp_q[$];
  logic [2:0] m_idx = 3'd1;
  int         m_left = 0;

  logic [3:0] ph [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  step_motor_ctrl #(
    .CNT_W(CNT_W),
    .DIV_W(DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_half    (cmd_half),
    .cmd_steps   (cmd_steps),
    .cmd_div     (cmd_div),
    .abort       (abort),
    .motor_sense (motor_sense),
    .step_motor  (step_motor),
    .busy        (busy),
    .done        (done),
    .sense_cnt   (sense_cnt),
    .steps_left  (steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] c,
                      input logic d, input logic b);
    exp_t e;
    e.coil = c;
    e.done = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // ab: -1 none, 0 abort with command, >0 abort in that cycle
  task automatic do_move(input bit d, input bit h,
                         input int steps, input int dv,
                         input int ab, input bit hold);
    int   de;
    int   rc;
    int   c;
    exp_t e;
    de = (dv == 0) ? 1 : dv;
    if (steps == 0) begin
      push(4'b0000, 1'b1, 1'b0);
      push(4'b0000, 1'b0, 1'b0);
    end else begin
      m_left = steps;
      if (!h && !m_idx[0]) m_idx = m_idx + 3'd1;
      rc = (ab > 0) ? ab : steps * de;
      for (int k = 1; k <= rc; k++) begin
        push(ph[m_idx], 1'b0, 1'b1);
        if (k % de == 0) begin
          m_idx = d ? m_idx + 3'(h ? 1 : 2)
                    : m_idx - 3'(h ? 1 : 2);
          m_left--;
        end
      end
      for (int k = 0; k < de; k++)
        push(ph[m_idx], 1'b0, 1'b1);
      push(4'b0000, 1'b1, 1'b0);
    end
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_half  = h;
    cmd_steps = CNT_W'(steps);
    cmd_div   = DIV_W'(dv);
    abort     = (ab == 0);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    abort = 1'b0;
    c = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("coil", 32'(step_motor), 32'(e.coil));
      chk("done", 32'(done), 32'(e.done));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("ready", 32'(cmd_ready), 32'(!e.busy));
      if (c == 1 && steps != 0)
        chk("sclr", 32'(sense_cnt), 32'd0);
      abort = (c == ab);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
      c++;
    end
    abort = 1'b0;
    if (steps != 0)
      chk("left", 32'(steps_left), 32'(m_left));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_coil", 32'(step_motor), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_sense", 32'(sense_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_left", 32'(steps_left), 32'd0);
    @(negedge clk);

    do_move(1'b1, 1'b0, 4, 3, -1, 1'b0);
    chk("idx_fwd", 32'(m_idx), 32'd1);
    do_move(1'b0, 1'b1, 3, 1, -1, 1'b0);
    do_move(1'b1, 1'b0, 10, 2, 7, 1'b1);
    chk("abort_left", 32'(steps_left), 32'd7);
    do_move(1'b0, 1'b1, 2, 0, -1, 1'b0);
    do_move(1'b1, 1'b0, 0, 5, -1, 1'b0);
    do_move(1'b1, 1'b0, 3, 2, 0, 1'b0);

    fork
      do_move(1'b1, 1'b1, 40, 2, -1, 1'b0);
      begin
        repeat (3) @(negedge clk);
        repeat (12) begin
          motor_sense = 1'b1;
          repeat (3) @(negedge clk);
          motor_sense = 1'b0;
          repeat (3) @(negedge clk);
        end
      end
    join
    chk("sense12", 32'(sense_cnt), 32'd2);
    @(negedge clk);
    motor_sense = 1'b1;
    repeat (3) @(negedge clk);
    motor_sense = 1'b0;
    repeat (4) @(negedge clk);
    chk("sense_idle", 32'(sense_cnt), 32'd2);
    do_move(1'b1, 1'b0, 1, 1, -1, 1'b0);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_half  = 1'b1;
    cmd_steps = CNT_W'(20);
    cmd_div   = DIV_W'(4);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_coil", 32'(step_motor), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_left", 32'(steps_left), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_motor_ctrl.md
# step_motor_ctrl

Command-driven sequencer for the 4-phase unipolar step motor and its slot sensor. Accepts a move command (direction, full/half step, step count, step period), drives the coil pattern at the programmed rate, counts synchronized `motor_sense` pulses as a 0–9 digit for the 7-segment display, and reports completion. It sits between the mode/state logic and the `step_motor` pins.

## Interface
- `CNT_W`, 12: width of step count.
- `DIV_W`, 16: width of step period, in clocks.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high exactly when in IDLE.
- `cmd_dir`  in  1  1 = forward (index increments), 0 = reverse.
- `cmd_half`  in  1  1 = half-step, 0 = full-step.
- `cmd_steps`  in  CNT_W  number of steps to move.
- `cmd_div`  in  DIV_W  clocks per step; 0 is treated as 1.
- `abort`  in  1  stop the current move early.
- `motor_sense`  in  1  asynchronous sensor pulse.
- `step_motor`  out  4  coil drive.
- `busy`  out  1  high in RUN or STOP.
- `done`  out  1  one-cycle pulse at the end of a move.
- `sense_cnt`  out  4  sensor pulse count, 0–9, wraps to 0.
- `steps_left`  out  CNT_W  remaining steps.

## Operation
- **Phase table**, 3-bit index `idx`:
  - 0 = 1000, 1 = 1100, 2 = 0100, 3 = 0110, 4 = 0010, 5 = 0011, 6 = 0001, 7 = 1001.
  - Full-step moves `idx` ±2; half-step moves it ±1; arithmetic is mod 8.
  - A full-step move starting from an even `idx` first rounds to `idx+1`, applied at acceptance.
- `idx` persists across commands; the reset value is 1.
- **States:**
  - IDLE: `step_motor` = 0000.
  - RUN: `step_motor` = table[`idx`].
  - STOP: holds table[`idx`].
- **Transitions:**
  - IDLE→RUN on `cmd_valid && cmd_ready` with `cmd_steps` ≠ 0. Loads `steps_left` = `cmd_steps`, clears the divider and `sense_cnt`, and latches dir, half and div.
  - IDLE with `cmd_steps` = 0: no state change; `done` pulses the next cycle.
  - In RUN, the divider counts 0..div−1. At div−1: `idx` advances, `steps_left` decrements, and if `steps_left` was 1 the next state is STOP.
  - RUN→STOP on `abort`. `steps_left` keeps its value at abort.
  - STOP holds the final phase for div cycles, then goes to IDLE with `done` = 1 for that one transition cycle.
- **Sensor path:**
  - `motor_sense` passes through a 2-FF synchronizer and a rising-edge detect.
  - Each edge while `busy` increments `sense_cnt`; 9 wraps to 0.
  - Edges in IDLE are ignored. `sense_cnt` holds after `done` for display.
- **Simultaneous events:**
  - `abort` in IDLE is ignored, and a command in the same cycle is accepted.
  - `abort` coinciding with the final step: STOP, one `done`.
  - A sensor edge in the acceptance cycle: the clear wins.
  - `cmd_valid` while busy is held off (`cmd_ready` = 0).

## Timing
- **Reset values:** state IDLE, `idx` = 1, `step_motor` = 0000, `cmd_ready` = 1, `busy` = 0, `done` = 0, `sense_cnt` = 0, `steps_left` = 0. Reset mid-move de-energizes the coils immediately, since reset is asynchronous.
- **Registered outputs:** `step_motor`, `busy`, `done`, `sense_cnt` and `steps_left`, except `cmd_ready`, which is decoded from state.
- **Move latency:**
  - Coils energize one cycle after acceptance.
  - The first phase change occurs div cycles after RUN entry.
  - Total RUN time is `cmd_steps`×div cycles, then STOP for div cycles.
  - `done` is asserted (steps+1)×div+1 cycles after acceptance.
- **Sensor latency:** 3 clocks from the `motor_sense` rise to the `sense_cnt` update. Pulses shorter than 2 clocks may be missed.

## Structure
- Package `step_pkg`:
  - state enum (IDLE, RUN, STOP)
  - 8-entry phase table constant
  - reset index 1
  - BCD maximum 9
- Sub-module `sense_counter`: synchronizer, edge detect, mod-10 counter, with enable (`busy`) and clear (accept) inputs.

## Test plan
- **Reset:** release `rst` → `step_motor` = 0000, `cmd_ready` = 1, `sense_cnt` = 0.
- **Forward full-step:** `cmd_steps` = 4, div = 3, dir = 1.
  - Coils show 1100, 0110, 0011, 1001, 1100, each for 3 clocks (the last one is STOP).
  - `done` at cycle 16; `idx` ends at 1.
- **Reverse half-step:** `cmd_steps` = 3, div = 1 → 1100, 1000, 1001, 0001, then 0000 and `done`.
- **Abort:**
  - Move of 10 steps, div = 2, `abort` after the 3rd advance → STOP hold 2 cycles, `done`, `steps_left` = 7.
  - A second command is accepted only after `done`.
- **Sensor:** 12 `motor_sense` pulses during a long move → `sense_cnt` = 2. A pulse in IDLE leaves it unchanged, and a new acceptance clears it.
- **Edge cases:**
  - `cmd_steps` = 0 → `done` pulse with no coil activity.
  - `cmd_div` = 0 behaves as div = 1.
  - `abort` asserted in IDLE together with `cmd_valid` → command accepted.
